control_unit: RTL and testbench

- Control unit for the single-cycle ARM-subset datapath.
- Consumes the fetched instruction and the raw ALU flags. Drives every datapath control input plus a new PC write-enable.
- Holds the architectural NZCV register and evaluates condition codes against it.
- A small run-state FSM covers post-reset fetch latency, stops on illegal instructions, and keeps a retired-instruction counter for the testbench.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/cond_check.sv | 36 +++
 rtl/control_unit.sv | 173 +++++++++++++++++
 tb/tb_control_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ARM-subset control unit: opcode classes, DP
// commands, condition codes, ALU/immediate selects and run-state enum.
package ctrl_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluation of Cond against the architectural NZCV flags.
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Standard ARM condition table; NV never executes
    always_comb begin
        condex = 1'b0;
        case (cond)
            CC_EQ: condex = z;
            CC_NE: condex = ~z;
            CC_CS: condex = c;
            CC_CC: condex = ~c;
            CC_MI: condex = n;
            CC_PL: condex = ~n;
            CC_VS: condex = v;
            CC_VC: condex = ~v;
            CC_HI: condex = c & ~z;
            CC_LS: condex = ~c | z;
            CC_GE: condex = (n == v);
            CC_LT: condex = (n != v);
            CC_GT: condex = ~z & (n == v);
            CC_LE: condex = z | (n != v);
            CC_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Control unit for the single-cycle ARM-subset datapath: instruction decode,
// NZCV flag register, conditional qualification and the WAIT/RUN/HALT FSM.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic             Z,
    input  logic             N,
    input  logic             C,
    input  logic             V,
    output logic             PCSrc,
    output logic             PCEn,
    output logic [1:0]       RegSrc,
    output logic             RegWrite,
    output logic [1:0]       ImmSrc,
    output logic             ALUSrc,
    output logic [1:0]       ALUControl,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             Halted,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       s;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];
    assign cmd   = funct[4:1];
    assign s     = funct[0];

    // Register-address and offset fields belong to the datapath
    logic unused_fields;
    assign unused_fields = ^{Instr[19:16], Instr[11:0]};

    logic       alu_op, regw, memw, branch, nowrite, cmd_ok;
    logic [1:0] flagw;
    logic       pcs, illegal, condex;
    logic [3:0] flags;
    state_t     state;
    logic [3:0] wait_cnt;
    logic       exec;

    // Main decode: steering signals plus unqualified write intents
    always_comb begin
        alu_op   = 1'b0;
        regw     = 1'b0;
        memw     = 1'b0;
        branch   = 1'b0;
        RegSrc   = 2'b00;
        ImmSrc   = IMM_DP;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        case (op)
            OP_DP: begin
                alu_op = 1'b1;
                regw   = 1'b1;
                if (funct[5]) ALUSrc = 1'b1;
            end
            OP_MEM: begin
                ImmSrc = IMM_MEM;
                ALUSrc = 1'b1;
                if (funct[0]) begin
                    MemtoReg = 1'b1;
                    regw     = 1'b1;
                end else begin
                    RegSrc = 2'b10;
                    memw   = 1'b1;
                end
            end
            OP_BR: begin
                RegSrc = 2'b01;
                ImmSrc = IMM_BR;
                ALUSrc = 1'b1;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decode; non-DP instructions always add for address/target math
    always_comb begin
        ALUControl = ALU_ADD;
        nowrite    = 1'b0;
        cmd_ok     = 1'b1;
        flagw      = 2'b00;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                CMD_CMP: begin
                    ALUControl = ALU_SUB;
                    nowrite    = 1'b1;
                    cmd_ok     = s;
                end
                default: cmd_ok = 1'b0;
            endcase
            flagw[1] = s;
            flagw[0] = s & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
        end
    end

    assign illegal = (op == 2'b11) | (cond == CC_NV) | ~cmd_ok;
    assign pcs     = branch | ((rd == 4'd15) & regw);

    cond_check u_cond (
        .cond   (cond),
        .flags  (flags),
        .condex (condex)
    );

    // State gating is async-reset driven, so writes drop as soon as reset rises
    assign exec     = (state == ST_RUN) & ~illegal;
    assign PCEn     = exec;
    assign PCSrc    = exec & pcs & condex;
    assign RegWrite = exec & regw & condex & ~nowrite;
    assign MemWrite = exec & memw & condex;

    // Architectural NZCV register, written only by executed flag-setting ops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (exec && condex) begin
            if (flagw[1]) flags[3:2] <= {N, Z};
            if (flagw[0]) flags[1:0] <= {C, V};
        end
    end

    // Run-state FSM: fetch-latency wait, run, sticky halt; counts retired slots
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_WAIT;
            wait_cnt <= 4'd0;
            Halted   <= 1'b0;
            Retired  <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) state <= ST_RUN;
                    else                       wait_cnt <= wait_cnt + 4'd1;
                end
                ST_RUN: begin
                    if (illegal) begin
                        state  <= ST_HALT;
                        Halted <= 1'b1;
                    end else if (Retired != '1) begin
                        Retired <= Retired + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_HALT;
                    Halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode, condition evaluation, flags,
// halt on illegal instructions, reset abort and retired-count saturation.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'hE0821003;
    logic        Z = 1'b0, N = 1'b0, C = 1'b0, V = 1'b0;

    logic        PCSrc, PCEn, RegWrite, ALUSrc, MemWrite, MemtoReg, Halted;
    logic [1:0]  RegSrc, ImmSrc, ALUControl;
    logic [15:0] Retired;

    logic        s_pcsrc, s_pcen, s_regwrite, s_alusrc, s_memwrite, s_memtoreg, s_halted;
    logic [1:0]  s_regsrc, s_immsrc, s_aluctl;
    logic [3:0]  s_retired;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    control_unit #(.CNT_W(16), .WAIT_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .Instr(Instr),
        .Z(Z), .N(N), .C(C), .V(V),
        .PCSrc(PCSrc), .PCEn(PCEn), .RegSrc(RegSrc), .RegWrite(RegWrite),
        .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .Halted(Halted), .Retired(Retired)
    );

    control_unit #(.CNT_W(4), .WAIT_CYCLES(1)) dut4 (
        .clock(clock), .reset(reset), .Instr(Instr),
        .Z(Z), .N(N), .C(C), .V(V),
        .PCSrc(s_pcsrc), .PCEn(s_pcen), .RegSrc(s_regsrc), .RegWrite(s_regwrite),
        .ImmSrc(s_immsrc), .ALUSrc(s_alusrc), .ALUControl(s_aluctl),
        .MemWrite(s_memwrite), .MemtoReg(s_memtoreg), .Halted(s_halted), .Retired(s_retired)
    );

    task automatic apply(input logic [31:0] i, input logic [3:0] nzcv);
        Instr = i;
        {N, Z, C, V} = nzcv;
        @(negedge clock);
    endtask

    task automatic commit();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(32'hE0821003, 4'b0000);
        repeat (2) @(posedge clock);
        #1;
        vectors++; if (Halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b want 0", Halted); end
        vectors++; if (Retired !== 16'd0) begin miscompares++; $display("FAIL reset_retired got %0d want 0", Retired); end
        vectors++; if ({PCEn, RegWrite, MemWrite, PCSrc} !== 4'b0000) begin miscompares++; $display("FAIL reset_enables got %b want 0000", {PCEn, RegWrite, MemWrite, PCSrc}); end
        vectors++; if (dut.flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b want 0000", dut.flags); end
        reset = 1'b0;
    endtask

    task automatic test_adds();
        apply(32'hE0921003, 4'b0010);
        vectors++; if ({PCEn, RegWrite} !== 2'b00) begin miscompares++; $display("FAIL wait_enables got %b want 00", {PCEn, RegWrite}); end
        commit();
        vectors++; if (Retired !== 16'd0) begin miscompares++; $display("FAIL wait_retired got %0d want 0", Retired); end
        @(negedge clock);
        vectors++; if ({PCEn, RegWrite, ALUSrc} !== 3'b110) begin miscompares++; $display("FAIL adds_ctl got %b want 110", {PCEn, RegWrite, ALUSrc}); end
        vectors++; if (ALUControl !== 2'b00) begin miscompares++; $display("FAIL adds_alu got %b want 00", ALUControl); end
        commit();
        vectors++; if (dut.flags !== 4'b0010) begin miscompares++; $display("FAIL adds_flags got %b want 0010", dut.flags); end
        vectors++; if (Retired !== 16'd1) begin miscompares++; $display("FAIL adds_retired got %0d want 1", Retired); end
    endtask

    task automatic test_cmp_beq();
        apply(32'hE3510005, 4'b0110);
        vectors++; if ({RegWrite, ALUSrc, ALUControl} !== 4'b0101) begin miscompares++; $display("FAIL cmp_ctl got %b want 0101", {RegWrite, ALUSrc, ALUControl}); end
        commit();
        vectors++; if (dut.flags !== 4'b0110) begin miscompares++; $display("FAIL cmp_flags got %b want 0110", dut.flags); end
        apply(32'h0A000002, 4'b0000);
        vectors++; if ({PCSrc, PCEn} !== 2'b11) begin miscompares++; $display("FAIL beq_taken got %b want 11", {PCSrc, PCEn}); end
        vectors++; if ({ImmSrc, RegSrc} !== 4'b1001) begin miscompares++; $display("FAIL beq_steer got %b want 1001", {ImmSrc, RegSrc}); end
        commit();
        vectors++; if (dut.flags !== 4'b0110) begin miscompares++; $display("FAIL beq_flags_held got %b want 0110", dut.flags); end
    endtask

    task automatic test_beq_not_taken();
        apply(32'hE3510005, 4'b0000);
        commit();
        vectors++; if (dut.flags !== 4'b0000) begin miscompares++; $display("FAIL cmp2_flags got %b want 0000", dut.flags); end
        apply(32'h0A000002, 4'b0100);
        vectors++; if ({PCSrc, PCEn} !== 2'b01) begin miscompares++; $display("FAIL beq_not_taken got %b want 01", {PCSrc, PCEn}); end
        commit();
        vectors++; if (Retired !== 16'd5) begin miscompares++; $display("FAIL nt_retired got %0d want 5", Retired); end
    endtask

    task automatic test_mem_pc();
        apply(32'hE5821004, 4'b0000);
        vectors++; if ({MemWrite, RegWrite, MemtoReg} !== 3'b100) begin miscompares++; $display("FAIL str_ctl got %b want 100", {MemWrite, RegWrite, MemtoReg}); end
        vectors++; if ({RegSrc, ImmSrc, ALUSrc} !== 5'b10011) begin miscompares++; $display("FAIL str_steer got %b want 10011", {RegSrc, ImmSrc, ALUSrc}); end
        commit();
        apply(32'hE5921004, 4'b0000);
        vectors++; if ({MemWrite, RegWrite, MemtoReg, ALUControl} !== 5'b01100) begin miscompares++; $display("FAIL ldr_ctl got %b want 01100", {MemWrite, RegWrite, MemtoReg, ALUControl}); end
        commit();
        apply(32'hE092F003, 4'b1000);
        vectors++; if ({PCSrc, RegWrite} !== 2'b11) begin miscompares++; $display("FAIL addpc_ctl got %b want 11", {PCSrc, RegWrite}); end
        commit();
        vectors++; if (dut.flags !== 4'b1000) begin miscompares++; $display("FAIL addpc_flags got %b want 1000", dut.flags); end
        apply(32'h00821003, 4'b0100);
        vectors++; if ({PCEn, RegWrite} !== 2'b10) begin miscompares++; $display("FAIL addeq_fail got %b want 10", {PCEn, RegWrite}); end
        commit();
        vectors++; if (Retired !== 16'd9) begin miscompares++; $display("FAIL mem_retired got %0d want 9", Retired); end
    endtask

    task automatic test_illegal();
        apply(32'hEF000000, 4'b0000);
        vectors++; if ({PCEn, RegWrite, MemWrite, PCSrc} !== 4'b0000) begin miscompares++; $display("FAIL illegal_enables got %b want 0000", {PCEn, RegWrite, MemWrite, PCSrc}); end
        commit();
        vectors++; if (Halted !== 1'b1) begin miscompares++; $display("FAIL halted got %b want 1", Halted); end
        vectors++; if (Retired !== 16'd9) begin miscompares++; $display("FAIL halt_retired got %0d want 9", Retired); end
        apply(32'hE0921003, 4'b1111);
        vectors++; if ({PCEn, RegWrite} !== 2'b00) begin miscompares++; $display("FAIL halt_gated got %b want 00", {PCEn, RegWrite}); end
        commit();
        vectors++; if ({Retired, Halted} !== {16'd9, 1'b1}) begin miscompares++; $display("FAIL halt_hold got %0d/%b want 9/1", Retired, Halted); end
        vectors++; if (dut.flags !== 4'b1000) begin miscompares++; $display("FAIL halt_flags got %b want 1000", dut.flags); end
        reset = 1'b1;
        #1;
        vectors++; if ({Halted, Retired} !== 17'd0) begin miscompares++; $display("FAIL halt_reset got %b/%0d want 0/0", Halted, Retired); end
        commit();
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        apply(32'hE0821003, 4'b0000);
        commit();
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            commit();
            if (k == 15) begin
                vectors++; if (s_retired !== 4'd15) begin miscompares++; $display("FAIL sat_reach got %0d want 15", s_retired); end
            end
        end
        vectors++; if (s_retired !== 4'd15) begin miscompares++; $display("FAIL sat_hold got %0d want 15", s_retired); end
        vectors++; if (Retired !== 16'd17) begin miscompares++; $display("FAIL wide_retired got %0d want 17", Retired); end
        Instr = 32'hE3410005; #1;
        vectors++; if (PCEn !== 1'b0) begin miscompares++; $display("FAIL cmp_nos_illegal got %b want 0", PCEn); end
        Instr = 32'hE0221003; #1;
        vectors++; if (PCEn !== 1'b0) begin miscompares++; $display("FAIL bad_cmd_illegal got %b want 0", PCEn); end
        Instr = 32'hF0821003; #1;
        vectors++; if (PCEn !== 1'b0) begin miscompares++; $display("FAIL cond_nv_illegal got %b want 0", PCEn); end
        Instr = 32'hE0821003; #1;
        vectors++; if ({PCEn, RegWrite} !== 2'b11) begin miscompares++; $display("FAIL pre_abort got %b want 11", {PCEn, RegWrite}); end
        reset = 1'b1; #1;
        vectors++; if ({PCEn, RegWrite, Retired} !== 18'd0) begin miscompares++; $display("FAIL abort got %b/%b/%0d want 0/0/0", PCEn, RegWrite, Retired); end
        commit();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_adds();
        test_cmp_beq();
        test_beq_not_taken();
        test_mem_pc();
        test_illegal();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
